mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified 16-bit memory between two requesters: the instruction-fetch stage and the data-memory stage.
- The data-memory stage is driven by the EX/MEM pipeline register's mem_read/mem_write, address (ALU result) and store data (reg_data2).
- Sequences variable-latency memory accesses through a req/ready handshake.
- Generates the stall signals that freeze the fetch stage and the whole pipeline while accesses are outstanding.

Parameters:
- ADDR_W, 16, address width of both requesters and the memory.
- DATA_W, 16, data width.
- TIMEOUT, 15, max cycles in a grant state without mem_ready before the access is aborted (1..255).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, valid when if_done=1
- if_done  out  1  one-cycle fetch completion pulse
- dm_read  in  1  load request (EX/MEM mem_read)
- dm_write  in  1  store request (EX/MEM mem_write)
- dm_addr  in  ADDR_W  data address (EX/MEM ALU result)
- dm_wdata  in  DATA_W  store data (EX/MEM reg_data2)
- dm_rdata  out  DATA_W  load data, valid when dm_done=1
- dm_done  out  1  one-cycle data completion pulse
- stall_if  out  1  hold PC and IF/ID
- stall_mem  out  1  freeze all pipeline registers
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion, one-cycle pulse
- timeout_err  out  1  sticky: an access was aborted
- proto_err  out  1  sticky: dm_read and dm_write seen together

Behaviour:
- States: IDLE, FETCH, DATA.
- Reset (reset_n=0, async, any state including mid-access):
  - state=IDLE; mem_req, mem_we, if_done, dm_done, timeout_err and proto_err all 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata all 0; wait counter 0.
- Registered outputs: mem_req/mem_we/mem_addr/mem_wdata, latched on entry to FETCH/DATA and held constant for the whole grant.
  - mem_req=1 exactly while state is FETCH or DATA.
- Arbitration from IDLE, sampled at the clock edge:
  - Data request (dm_read|dm_write) goes to DATA; else if_req goes to FETCH; else stay IDLE.
  - Data has priority because it belongs to the older instruction.
- Completion: in FETCH/DATA, the edge with mem_ready=1 completes the access.
  - FETCH: if_rdata<=mem_rdata, if_done=1 for the next cycle.
  - DATA load: dm_rdata<=mem_rdata. DATA store: dm_rdata unchanged. Either way dm_done=1 for the next cycle.
- Next state at completion considers only the other requester:
  - FETCH to DATA if a data request is present, else IDLE.
  - DATA to FETCH if if_req, else IDLE.
  - Consequences: alternating traffic has zero bubbles; back-to-back requests from the same requester have exactly one IDLE cycle; fetch cannot be starved by consecutive loads/stores.
- Latency: request sampled at edge N, mem_req from N, mem_ready at edge N+k, done pulse in cycle N+k. Minimum k=1.
- mem_ready while IDLE is ignored.
- Stalls (combinational):
  - stall_mem = (dm_read|dm_write) & ~dm_done
  - stall_if = (if_req & ~if_done) | stall_mem
- Requester contract: request and address/data stay stable until done. The request may drop or change in the cycle after done.
- dm_read & dm_write together: treated as a store; proto_err set and held until reset.
- Timeout:
  - Wait counter clears on entry to FETCH/DATA and increments each grant cycle without mem_ready.
  - When counter==TIMEOUT-1 and no mem_ready: abort.
  - Abort effects: done pulse for the granted requester, rdata<=0, timeout_err set (sticky), next state per completion rule.
  - mem_ready on the abort edge counts as normal completion.

Test Plan:
- Reset release with only if_req=1, if_addr=0x0010, memory k=2 returning 0xABCD -> mem_req high 2 cycles; if_done pulses once with if_rdata=0xABCD; stall_if low after the pulse.
- dm_read@0x0200 and if_req@0x0011 asserted in the same cycle, k=1, data 0x1234 -> DATA granted first, dm_rdata=0x1234, then FETCH immediately with no IDLE cycle; stall_if held until if_done.
- Store dm_write, dm_addr=0x0300, dm_wdata=0x5A5A -> mem_we=1, mem_addr=0x0300, mem_wdata=0x5A5A stable for all grant cycles; dm_done pulses; dm_rdata unchanged.
- Two consecutive loads, if_req held -> order DATA, FETCH, DATA; with no if_req, one IDLE cycle between the loads.
- mem_ready never asserted, TIMEOUT=15 -> abort after 15 grant cycles; done pulse, rdata=0, timeout_err=1 persists; next request still serviced.
- reset_n low mid-DATA grant -> mem_req and all outputs 0 immediately, without waiting for a clock edge; a late mem_ready after release is ignored in IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the
// data-memory stage, with pipeline stall generation and an access watchdog.
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              dm_read,
   input  logic              dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_done,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              timeout_err,
   output logic              proto_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic       dm_req;
   logic       granted;
   logic       expired;
   logic       finish;
   logic       enter_fetch;
   logic       enter_data;

   // A grant ends either on mem_ready or when the watchdog runs out; a
   // mem_ready on the last allowed cycle still counts as a real completion.
   always_comb begin
      dm_req  = dm_read | dm_write;
      granted = (state != IDLE);
      expired = granted & ~mem_ready & (wait_cnt == WAIT_LAST);
      finish  = granted & (mem_ready | expired);
   end

   // At completion only the other requester is considered, so neither side
   // can monopolise the port with back-to-back requests.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (dm_req)      state_nxt = DATA;
            else if (if_req) state_nxt = FETCH;
         end
         FETCH: begin
            if (finish) state_nxt = dm_req ? DATA : IDLE;
         end
         DATA: begin
            if (finish) state_nxt = if_req ? FETCH : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      enter_fetch = (state_nxt == FETCH) && (state != FETCH);
      enter_data  = (state_nxt == DATA) && (state != DATA);
      stall_mem   = dm_req & ~dm_done;
      stall_if    = (if_req & ~if_done) | stall_mem;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         if_rdata    <= '0;
         dm_rdata    <= '0;
         if_done     <= 1'b0;
         dm_done     <= 1'b0;
         timeout_err <= 1'b0;
         proto_err   <= 1'b0;
         wait_cnt    <= 8'd0;
      end else begin
         if_done <= 1'b0;
         dm_done <= 1'b0;
         mem_req <= (state_nxt != IDLE);
         if (dm_read & dm_write) proto_err <= 1'b1;
         if (expired) timeout_err <= 1'b1;
         if (granted && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
         // An aborted access returns zero so a stale value is never consumed.
         if (finish) begin
            if (state == FETCH) begin
               if_done  <= 1'b1;
               if_rdata <= expired ? '0 : mem_rdata;
            end else begin
               dm_done <= 1'b1;
               if (expired)     dm_rdata <= '0;
               else if (!mem_we) dm_rdata <= mem_rdata;
            end
         end
         // Bus fields are captured once on grant entry and held for the grant.
         if (enter_fetch) begin
            mem_addr <= if_addr;
            mem_we   <= 1'b0;
            wait_cnt <= 8'd0;
         end else if (enter_data) begin
            mem_addr  <= dm_addr;
            mem_we    <= dm_write;
            mem_wdata <= dm_wdata;
            wait_cnt  <= 8'd0;
         end else if (state_nxt == IDLE) begin
            mem_we <= 1'b0;
         end
      end
   end

   a_req_tracks_grant : assert property (
      @(posedge clk) disable iff (!reset_n) mem_req == (state != IDLE));

   a_bus_stable : assert property (
      @(posedge clk) disable iff (!reset_n)
      (granted && !finish) |=> ($stable(mem_addr) && $stable(mem_we) && $stable(mem_wdata)));

endmodule
